wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_BITS, default 32, write-data width; REG_BITS, default 5, register-address width; FIFO_DEPTH, default 2, long-latency result buffer entries (power of 2, minimum 2).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid_i  input  1  single-cycle pipe result valid; no backpressure.
REQ-005 alu_rd_i  input  REG_BITS  ALU destination register.
REQ-006 alu_data_i  input  DATA_BITS  ALU result.
REQ-007 lsu_valid_i  input  1  long-latency (load/mul/div) result valid.
REQ-008 lsu_ready_o  output  1  long-latency result accepted when high with lsu_valid_i.
REQ-009 lsu_rd_i  input  REG_BITS  long-latency destination register.
REQ-010 lsu_data_i  input  DATA_BITS  long-latency result.
REQ-011 issue_i  input  1  long-latency op issued this cycle.
REQ-012 issue_rd_i  input  REG_BITS  destination of issued op.
REQ-013 rs1_addr_i, rs2_addr_i  input  REG_BITS each  source registers of instruction in decode.
REQ-014 stall_o  output  1  decode SHALL hold; a source is pending.
REQ-015 wb_reg_wr_o  output  1  register-file write enable.
REQ-016 wb_rd_addr_o  output  REG_BITS  register-file write address.
REQ-017 wb_rd_data_o  output  DATA_BITS  register-file write data.

Function
REQ-018 wb_reg_wr_o, wb_rd_addr_o, wb_rd_data_o SHALL be registered: 1-cycle latency from winning source to output.
REQ-019 ALU SHALL have absolute priority; alu_valid_i with alu_rd_i != 0 SHALL produce a write the next cycle.
REQ-020 Long-latency results SHALL enter a FIFO_DEPTH-entry FIFO on lsu_valid_i && lsu_ready_o; lsu_ready_o = FIFO not full (combinational on count only, not on lsu_valid_i).
REQ-021 FIFO head SHALL be popped and written when FIFO non-empty and no ALU write wins this cycle.
REQ-022 FIFO empty and lsu_valid_i with no ALU write: entry SHALL still pass through the FIFO (no bypass); minimum LSU latency 2 cycles.
REQ-023 Simultaneous push and pop on a full FIFO SHALL NOT occur: ready is low when full; push and pop when partially full SHALL keep count unchanged.
REQ-024 Any write with rd = 0 SHALL be dropped: wb_reg_wr_o low, FIFO pop still performed.
REQ-025 Scoreboard pending[2**REG_BITS] SHALL set bit issue_rd_i on issue_i (rd != 0), and clear bit rd when an LSU entry with that rd is popped.
REQ-026 Set and clear of the same bit in one cycle: set SHALL win.
REQ-027 ALU writes SHALL NOT modify pending.
REQ-028 stall_o = (rs1 != 0 && pending[rs1]) || (rs2 != 0 && pending[rs2]); combinational, including the cycle the clearing write appears on wb_* (write-then-read resolved by the register file next cycle).
REQ-029 pending[0] SHALL read as 0 always.

Reset
REQ-030 On rst_n low, asynchronously: wb_reg_wr_o = 0, wb_rd_addr_o = 0, wb_rd_data_o = 0, FIFO count/pointers = 0, pending = 0; lsu_ready_o = 1, stall_o = 0 after reset.
REQ-031 Reset mid-operation SHALL discard buffered results and pending state; no write SHALL be issued in the first cycle after rst_n rises.

Structure
REQ-032 DATA_BITS, REG_BITS, REG_NUMS and struct wb_req_t {rd, data} SHALL live in shared package cpu_pkg.
REQ-033 FIFO SHALL be sub-module wb_fifo (parameterized by depth and wb_req_t); scoreboard and arbitration stay in wb_arbiter.

Verification
REQ-034 ALU valid rd=5 data=0x1234 every cycle for 3 cycles, LSU valid rd=7 -> LSU accepted twice then lsu_ready_o=0; x7 written only in cycle after ALU stops.
REQ-035 issue_i rd=9; rs1=9 -> stall_o=1 until LSU rd=9 data=0xDEADBEEF popped; wb_* shows x9=0xDEADBEEF, stall_o=0 next cycle.
REQ-036 issue_i rd=3 same cycle LSU rd=3 pops -> pending[3] stays 1, stall_o=1 with rs2=3.
REQ-037 ALU rd=0 and LSU rd=0 -> wb_reg_wr_o never asserted; FIFO drains, count returns to 0.
REQ-038 FIFO full, pending[4]=1, rst_n low mid-cycle -> outputs 0 immediately, lsu_ready_o=1, stall_o=0 for rs1=4, no write after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the writeback request record used by the writeback path
package cpu_pkg;
  localparam int DATA_BITS = 32;
  localparam int REG_BITS = 5;
  localparam int REG_NUMS = 2 ** REG_BITS;
  typedef struct packed {
    logic [REG_BITS-1:0]  rd;
    logic [DATA_BITS-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small circular buffer holding long-latency results until the writeback port is free
// Ports: push_i/data_i enqueue, pop_i dequeues head_o, full_o/empty_o report occupancy.
module wb_fifo import cpu_pkg::*; #(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    push  = push_i && !full_o;
    pop   = pop_i && !empty_o;
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= data_i;
  assign head_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and long-latency results onto one register-file write port and tracks pending loads
// Ports: alu_* single-cycle results (always win), lsu_* buffered long-latency results with ready,
// issue_* marks destinations pending, rs1/rs2 drive stall_o, wb_* is the registered write port.
module wb_arbiter import cpu_pkg::*; #(
  parameter int DATA_BITS  = cpu_pkg::DATA_BITS,
  parameter int REG_BITS   = cpu_pkg::REG_BITS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid_i,
  input  logic [REG_BITS-1:0]  alu_rd_i,
  input  logic [DATA_BITS-1:0] alu_data_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [REG_BITS-1:0]  lsu_rd_i,
  input  logic [DATA_BITS-1:0] lsu_data_i,
  input  logic                 issue_i,
  input  logic [REG_BITS-1:0]  issue_rd_i,
  input  logic [REG_BITS-1:0]  rs1_addr_i,
  input  logic [REG_BITS-1:0]  rs2_addr_i,
  output logic                 stall_o,
  output logic                 wb_reg_wr_o,
  output logic [REG_BITS-1:0]  wb_rd_addr_o,
  output logic [DATA_BITS-1:0] wb_rd_data_o
);
  localparam int NREGS = 2 ** REG_BITS;
  wb_req_t lsu_req, head;
  logic full, empty, alu_win, pop, push;
  logic [NREGS-1:0] pend_q, pend_d, set_v, clr_v;
  logic wr_q, wr_d;
  logic [REG_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};
  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(wb_req_t)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .data_i(lsu_req),
    .pop_i(pop), .head_o(head), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    alu_win     = alu_valid_i && alu_rd_i != '0;
    lsu_ready_o = !full;
    push        = lsu_valid_i && !full;
    // a head with rd=0 is still popped; it just produces no write
    pop         = !empty && !alu_win;
    set_v       = issue_i ? NREGS'(1) << issue_rd_i : '0;
    clr_v       = pop ? NREGS'(1) << head.rd : '0;
    // set applied after clear so a same-cycle reissue keeps the register pending
    pend_d      = ((pend_q & ~clr_v) | set_v) & ~NREGS'(1);
    wr_d        = alu_win || (pop && head.rd != '0);
    addr_d      = alu_win ? alu_rd_i : wr_d ? head.rd : addr_q;
    data_d      = alu_win ? alu_data_i : wr_d ? head.data : data_q;
    stall_o     = (rs1_addr_i != '0 && pend_q[rs1_addr_i]) || (rs2_addr_i != '0 && pend_q[rs2_addr_i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q <= '0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  assign wb_reg_wr_o  = wr_q;
  assign wb_rd_addr_o = addr_q;
  assign wb_rd_data_o = data_q;
endmodule
